// File: rtl/wb_arbiter_if.sv
// Bus-side signal bundle of the two-master Wishbone arbiter.
// The arbiter uses the slave modport; the masters/mux side uses master.
interface wb_arbiter_if;
    logic cpu_cyc_i;
    logic cpu_stb_i;
    logic ext_cyc_i;
    logic ext_stb_i;
    logic ack_i;
    logic tmo_clr_i;
    logic cpu_cyc_o;
    logic cpu_stb_o;
    logic ext_cyc_o;
    logic ext_stb_o;
    logic bus_master_o;
    logic cpu_ack_o;
    logic ext_ack_o;
    logic tmo_err_o;
    logic tmo_flag_o;

    modport slave (
        input  cpu_cyc_i, cpu_stb_i, ext_cyc_i, ext_stb_i, ack_i, tmo_clr_i,
        output cpu_cyc_o, cpu_stb_o, ext_cyc_o, ext_stb_o, bus_master_o,
        output cpu_ack_o, ext_ack_o, tmo_err_o, tmo_flag_o
    );

    modport master (
        output cpu_cyc_i, cpu_stb_i, ext_cyc_i, ext_stb_i, ack_i, tmo_clr_i,
        input  cpu_cyc_o, cpu_stb_o, ext_cyc_o, ext_stb_o, bus_master_o,
        input  cpu_ack_o, ext_ack_o, tmo_err_o, tmo_flag_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master (CPU / ext) Wishbone arbiter with cycle lock, round-robin
// tie-break and a bus watchdog that force-terminates stalled accesses.
module wb_arbiter #(
    parameter int TMO_W    = 8,
    parameter int TIMEOUT  = 200,
    parameter bit EXT_PRIO = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    wb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_CPU, S_EXT} state_t;

    localparam bit              TMO_EN   = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_nxt;
    logic             last_gnt;
    logic             bus_master_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_err_q;
    logic             tmo_flag_q;
    logic             owner_stb;
    logic             tmo_fire;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner keeps the bus for as long as its cyc stays high.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.cpu_cyc_i && bus.ext_cyc_i) begin
                    if (EXT_PRIO && !last_gnt) begin
                        state_nxt = S_EXT;
                    end else begin
                        state_nxt = last_gnt ? S_CPU : S_EXT;
                    end
                end else if (bus.cpu_cyc_i) begin
                    state_nxt = S_CPU;
                end else if (bus.ext_cyc_i) begin
                    state_nxt = S_EXT;
                end
            end
            S_CPU: begin
                if (!bus.cpu_cyc_i) begin
                    state_nxt = bus.ext_cyc_i ? S_EXT : S_IDLE;
                end
            end
            S_EXT: begin
                if (!bus.ext_cyc_i) begin
                    state_nxt = bus.cpu_cyc_i ? S_CPU : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_cyc_o    = (state == S_CPU) && bus.cpu_cyc_i;
        bus.cpu_stb_o    = (state == S_CPU) && bus.cpu_stb_i;
        bus.ext_cyc_o    = (state == S_EXT) && bus.ext_cyc_i;
        bus.ext_stb_o    = (state == S_EXT) && bus.ext_stb_i;
        bus.cpu_ack_o    = (state == S_CPU) && ((bus.ack_i && bus.cpu_stb_i) || tmo_err_q);
        bus.ext_ack_o    = (state == S_EXT) && ((bus.ack_i && bus.ext_stb_i) || tmo_err_q);
        bus.bus_master_o = bus_master_q;
        bus.tmo_err_o    = tmo_err_q;
        bus.tmo_flag_o   = tmo_flag_q;
    end

    // Mux select follows the grant; IDLE keeps the last selection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_master_q <= 1'b0;
            last_gnt     <= 1'b0;
        end else if (state_nxt != state) begin
            if (state_nxt == S_EXT) begin
                bus_master_q <= 1'b1;
                last_gnt     <= 1'b1;
            end else if (state_nxt == S_CPU) begin
                bus_master_q <= 1'b0;
                last_gnt     <= 1'b0;
            end
        end
    end

    assign owner_stb = ((state == S_CPU) && bus.cpu_stb_i) ||
                       ((state == S_EXT) && bus.ext_stb_i);
    assign tmo_fire  = TMO_EN && owner_stb && !bus.ack_i &&
                       (tmo_cnt == TMO_LAST) && (state_nxt == state);

    // The forced-ack cycle counts as a termination, so counting restarts after it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt <= '0;
        end else if ((state_nxt != state) || !owner_stb || bus.ack_i || tmo_fire || tmo_err_q) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_err_q  <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_fire;
            if (tmo_fire) begin
                tmo_flag_q <= 1'b1;
            end else if (bus.tmo_clr_i) begin
                tmo_flag_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: one instance with a short
// watchdog (TIMEOUT=5) and one with the watchdog disabled (TIMEOUT=0).
module tb_wb_arbiter;

    logic clk;
    logic rst_n;
    logic cpu_cyc, cpu_stb, ext_cyc, ext_stb, ack, tmo_clr;

    wb_arbiter_if if5 ();
    wb_arbiter_if if0 ();

    assign if5.cpu_cyc_i = cpu_cyc;
    assign if5.cpu_stb_i = cpu_stb;
    assign if5.ext_cyc_i = ext_cyc;
    assign if5.ext_stb_i = ext_stb;
    assign if5.ack_i     = ack;
    assign if5.tmo_clr_i = tmo_clr;
    assign if0.cpu_cyc_i = cpu_cyc;
    assign if0.cpu_stb_i = cpu_stb;
    assign if0.ext_cyc_i = ext_cyc;
    assign if0.ext_stb_i = ext_stb;
    assign if0.ack_i     = ack;
    assign if0.tmo_clr_i = tmo_clr;

    wb_arbiter #(.TMO_W(8), .TIMEOUT(5), .EXT_PRIO(1'b1)) u_t5 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if5.slave)
    );

    wb_arbiter #(.TMO_W(8), .TIMEOUT(0), .EXT_PRIO(1'b1)) u_t0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if0.slave)
    );

    // Observed vector: cpu_cyc cpu_stb ext_cyc ext_stb bus_master cpu_ack ext_ack tmo_err tmo_flag
    logic [8:0] obs5, obs0;
    assign obs5 = {if5.cpu_cyc_o, if5.cpu_stb_o, if5.ext_cyc_o, if5.ext_stb_o, if5.bus_master_o,
                   if5.cpu_ack_o, if5.ext_ack_o, if5.tmo_err_o, if5.tmo_flag_o};
    assign obs0 = {if0.cpu_cyc_o, if0.cpu_stb_o, if0.ext_cyc_o, if0.ext_stb_o, if0.bus_master_o,
                   if0.cpu_ack_o, if0.ext_ack_o, if0.tmo_err_o, if0.tmo_flag_o};

    typedef struct {
        bit         sel;
        logic [8:0] exp;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors;
    int    miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input bit sel, input logic [8:0] exp);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t       e;
        string      tag;
        logic [8:0] obs;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed no entry, expected one pending entry");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = e.sel ? obs0 : obs5;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s (dut %0s): observed %b expected %b", tag, e.sel ? "t0" : "t5", obs, e.exp);
            end
        end
    endtask

    // One clock: advance, drive {cpu_cyc,cpu_stb,ext_cyc,ext_stb,ack,tmo_clr}, then compare.
    task automatic apply(input string tag, input bit sel, input logic [5:0] in, input logic [8:0] exp);
        push(tag, sel, exp);
        @(posedge clk);
        #1;
        {cpu_cyc, cpu_stb, ext_cyc, ext_stb, ack, tmo_clr} = in;
        #1;
        check_pop();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        {cpu_cyc, cpu_stb, ext_cyc, ext_stb, ack, tmo_clr} = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        push("reset_t5", 1'b0, 9'b000000000);
        check_pop();
        push("reset_t0", 1'b1, 9'b000000000);
        check_pop();
        #2 rst_n = 1'b1;

        // CPU alone: grant one cycle after request, ack routed to CPU only
        apply("cpu_req_idle",  1'b0, 6'b110000, 9'b000000000);
        apply("cpu_granted",   1'b0, 6'b110000, 9'b110000000);
        apply("cpu_wait",      1'b0, 6'b110000, 9'b110000000);
        apply("cpu_ack",       1'b0, 6'b110010, 9'b110001000);
        apply("cpu_release",   1'b0, 6'b000000, 9'b000000000);

        // Simultaneous request after a CPU grant: ext wins, then hands back to CPU
        apply("both_idle",     1'b0, 6'b111100, 9'b000000000);
        apply("ext_granted",   1'b0, 6'b111100, 9'b001110000);
        apply("ext_ack",       1'b0, 6'b111110, 9'b001110100);
        apply("ext_drop",      1'b0, 6'b110000, 9'b000010000);
        apply("cpu_after_ext", 1'b0, 6'b110000, 9'b110000000);

        // Cycle lock: CPU holds cyc (stb low) while ext waits
        apply("cpu_hold_nostb", 1'b0, 6'b100000, 9'b100000000);
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("lock_%0d", i), 1'b0, 6'b101100, 9'b100000000);
        end
        apply("cpu_drop_lock",  1'b0, 6'b001100, 9'b000000000);
        apply("ext_after_lock", 1'b0, 6'b001100, 9'b001110000);
        apply("ext_drop_idle",  1'b0, 6'b000000, 9'b000010000);
        apply("idle_hold_sel",  1'b0, 6'b000000, 9'b000010000);

        // Tie after an ext grant goes to CPU; then stall into the watchdog
        apply("rr_both_idle",  1'b0, 6'b111100, 9'b000010000);
        apply("rr_cpu_wins",   1'b0, 6'b111100, 9'b110000000);
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("stall_%0d", i), 1'b0, 6'b110000, 9'b110000000);
        end
        apply("tmo_forced",    1'b0, 6'b110000, 9'b110001011);
        apply("tmo_clr_req",   1'b0, 6'b100001, 9'b100000001);
        apply("tmo_cleared",   1'b0, 6'b100000, 9'b100000000);
        apply("tmo_release",   1'b0, 6'b000000, 9'b000000000);

        // Second stall: clear coincides with the firing cycle, ack_i lands in the forced cycle
        apply("stall2_idle",   1'b0, 6'b110000, 9'b000000000);
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("stall2_%0d", i), 1'b0, 6'b110000, 9'b110000000);
        end
        apply("stall2_fire_clr", 1'b0, 6'b110001, 9'b110000000);
        apply("forced_with_ack", 1'b0, 6'b110010, 9'b110001011);
        apply("set_won",         1'b0, 6'b000000, 9'b000000001);
        apply("flag_clr2",       1'b0, 6'b000001, 9'b000000001);
        apply("flag_low2",       1'b0, 6'b000000, 9'b000000000);

        // Watchdog disabled: 300 stalled cycles, no forced ack, flag stays low
        apply("t0_idle",       1'b1, 6'b110000, 9'b000000000);
        for (int i = 0; i < 300; i++) begin
            apply($sformatf("t0_stall_%0d", i), 1'b1, 6'b110000, 9'b110000000);
        end
        apply("t0_release",    1'b1, 6'b000000, 9'b000000000);

        // Asynchronous reset in the middle of an ext transfer
        apply("rst_ext_req",   1'b1, 6'b001100, 9'b000000000);
        apply("rst_ext_xfer",  1'b1, 6'b001110, 9'b001110100);
        #2 rst_n = 1'b0;
        #1;
        push("async_rst_t0", 1'b1, 9'b000000000);
        check_pop();
        push("async_rst_t5", 1'b0, 9'b000000000);
        check_pop();
        #1 rst_n = 1'b1;
        #1;
        push("post_rst_idle_t0", 1'b1, 9'b000000000);
        check_pop();
        push("post_rst_idle_t5", 1'b0, 9'b000000000);
        check_pop();
        apply("post_rst_grant_t0", 1'b1, 6'b001100, 9'b001110000);
        push("post_rst_grant_t5", 1'b0, 9'b001110000);
        check_pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
